fetch_stage: RTL and testbench

- Instruction-fetch stage at the front of the pipeline; the consumer of the next-PC that the write-back stage produces.
- Generates sequential instruction-memory read requests, pairs each in-order response with its PC, and buffers the results for decode.
- A redirect (from write-back PC select) restarts fetch at a new address and discards all stale instructions, including those still in flight.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response
// channel and the decode-side instruction handshake.
interface fetch_stage_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential imem requests, in-order pairing of responses
// with their PCs, a decode buffer, and redirect flushing of stale in-flight responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  fetch_stage_if.master  bus
);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

  typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e        state_r;
  state_e        state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW-1:0] discard_r;
  logic [CW-1:0] discard_nxt_s;
  logic [CW-1:0] inflight_s;
  logic [CW-1:0] buf_count_r;
  logic [AW-1:0] tag_wr_r;
  logic [AW-1:0] tag_rd_r;
  logic [AW-1:0] buf_wr_r;
  logic [AW-1:0] buf_rd_r;
  logic [31:0]   tag_mem_r   [BUF_DEPTH];
  logic [31:0]   buf_pc_r    [BUF_DEPTH];
  logic [31:0]   buf_instr_r [BUF_DEPTH];
  logic          credit_s;
  logic          req_s;
  logic          grant_s;
  logic          rsp_s;
  logic          push_s;
  logic          pop_s;
  logic          redirect_s;

  // Handshake qualification; credits use registered occupancy, so a pop frees a slot next cycle.
  always_comb begin
    credit_s   = ({1'b0, outstanding_r} + {1'b0, buf_count_r}) < DEPTH_W;
    redirect_s = bus.redirect_i;
    if (rst && (state_r == ST_FETCH)) begin
      req_s = credit_s;
    end else begin
      req_s = 1'b0;
    end
    grant_s = req_s & bus.imem_gnt_i;
    rsp_s   = bus.imem_rvalid_i & (outstanding_r != ZERO_C);
    push_s  = rsp_s & (state_r == ST_FETCH) & ~redirect_s;
    pop_s   = (buf_count_r != ZERO_C) & bus.instr_ready_i & ~redirect_s;
  end

  // Next state, outstanding and discard counts; redirect overrides everything else.
  always_comb begin
    state_nxt_s       = state_r;
    outstanding_nxt_s = outstanding_r;
    discard_nxt_s     = discard_r;
    inflight_s        = outstanding_r + CW'(grant_s) - CW'(rsp_s);
    if (redirect_s) begin
      outstanding_nxt_s = inflight_s;
      discard_nxt_s     = inflight_s;
      if (inflight_s != ZERO_C) begin
        state_nxt_s = ST_FLUSH;
      end else begin
        state_nxt_s = ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          outstanding_nxt_s = inflight_s;
          discard_nxt_s     = ZERO_C;
          state_nxt_s       = ST_FETCH;
        end
        ST_FLUSH: begin
          outstanding_nxt_s = inflight_s;
          if (rsp_s && (discard_r != ZERO_C)) begin
            discard_nxt_s = discard_r - ONE_C;
          end else begin
            discard_nxt_s = discard_r;
          end
          if (discard_nxt_s == ZERO_C) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
        default: begin
          outstanding_nxt_s = inflight_s;
          discard_nxt_s     = ZERO_C;
          state_nxt_s       = ST_FETCH;
        end
      endcase
    end
  end

  // Control state: FSM, counters and fetch PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_FETCH;
      outstanding_r <= ZERO_C;
      discard_r     <= ZERO_C;
      fetch_pc_r    <= RESET_PC;
    end else begin
      state_r       <= state_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      if (redirect_s) begin
        fetch_pc_r <= bus.redirect_pc_i & 32'hFFFF_FFFC;
      end else if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  // Tag FIFO pointers; stale tags are dropped wholesale on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr_r <= {AW{1'b0}};
      tag_rd_r <= {AW{1'b0}};
    end else if (redirect_s) begin
      tag_wr_r <= {AW{1'b0}};
      tag_rd_r <= {AW{1'b0}};
    end else begin
      if (grant_s) begin
        tag_wr_r <= tag_wr_r + AW'(1'b1);
      end else begin
        tag_wr_r <= tag_wr_r;
      end
      if (push_s) begin
        tag_rd_r <= tag_rd_r + AW'(1'b1);
      end else begin
        tag_rd_r <= tag_rd_r;
      end
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_wr_r    <= {AW{1'b0}};
      buf_rd_r    <= {AW{1'b0}};
      buf_count_r <= ZERO_C;
    end else if (redirect_s) begin
      buf_wr_r    <= {AW{1'b0}};
      buf_rd_r    <= {AW{1'b0}};
      buf_count_r <= ZERO_C;
    end else begin
      if (push_s) begin
        buf_wr_r <= buf_wr_r + AW'(1'b1);
      end else begin
        buf_wr_r <= buf_wr_r;
      end
      if (pop_s) begin
        buf_rd_r <= buf_rd_r + AW'(1'b1);
      end else begin
        buf_rd_r <= buf_rd_r;
      end
      buf_count_r <= buf_count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Storage arrays; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (grant_s && !redirect_s) begin
      tag_mem_r[tag_wr_r] <= fetch_pc_r;
    end
    if (push_s) begin
      buf_pc_r[buf_wr_r]    <= tag_mem_r[tag_rd_r];
      buf_instr_r[buf_wr_r] <= bus.imem_rdata_i;
    end
  end

  // Output drive; the head is zeroed while the buffer is empty.
  always_comb begin
    bus.imem_req_o    = req_s;
    bus.imem_addr_o   = fetch_pc_r;
    bus.instr_valid_o = (buf_count_r != ZERO_C);
    if (buf_count_r != ZERO_C) begin
      bus.instr_o    = buf_instr_r[buf_rd_r];
      bus.instr_pc_o = buf_pc_r[buf_rd_r];
    end else begin
      bus.instr_o    = 32'h0000_0000;
      bus.instr_pc_o = 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight PCs (stale ones at the front), decode buffer of {pc, instr}.
  logic [31:0] m_pc;
  int          m_stale;
  logic [31:0] m_fly[$];
  logic [63:0] m_buf[$];
  logic [31:0] acc_pc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit model_req();
    return (m_stale == 0) && ((m_fly.size() + m_buf.size()) < DEPTH);
  endfunction

  task automatic compare_outputs();
    chk("req", {31'd0, bus.imem_req_o}, {31'd0, model_req()});
    chk("addr", bus.imem_addr_o, m_pc);
    chk("valid", {31'd0, bus.instr_valid_o}, {31'd0, (m_buf.size() != 0)});
    if (m_buf.size() != 0) begin
      chk("instr", bus.instr_o, m_buf[0][31:0]);
      chk("instr_pc", bus.instr_pc_o, m_buf[0][63:32]);
    end else begin
      chk("instr_idle", bus.instr_o, 32'h0000_0000);
      chk("instr_pc_idle", bus.instr_pc_o, 32'h0000_0000);
    end
  endtask

  // One clock: compare, drive inputs, advance the model, move to the next falling edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit gnt,
                       input bit rv, input logic [31:0] rdata, input bit rdy);
    bit          hs;
    bit          rsp;
    bit          pop;
    logic [31:0] tag;
    compare_outputs();
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rdata;
    bus.instr_ready_i = rdy;
    hs  = model_req() && gnt;
    rsp = rv && (m_fly.size() != 0);
    pop = (m_buf.size() != 0) && rdy;
    if (redir) begin
      if (rsp) tag = m_fly.pop_front();
      if (hs) m_fly.push_back(m_pc);
      m_stale = m_fly.size();
      m_buf.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        acc_pc.push_back(m_buf[0][63:32]);
        m_buf.delete(0);
      end
      if (rsp) begin
        tag = m_fly.pop_front();
        if (m_stale > 0) m_stale--;
        else m_buf.push_back({tag, rdata});
      end
      if (hs) begin
        m_fly.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, RPC);
    chk("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_pc", bus.instr_pc_o, 32'd0);
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'd0;
    bus.instr_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_pc    = RPC;
    m_stale = 0;
    m_fly.delete();
    m_buf.delete();
    acc_pc.delete();
    #1;
  endtask

  initial begin
    bit rv;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'd0;
    bus.instr_ready_i = 1'b0;
    @(negedge clk);

    // Streaming: grant always, 1-cycle response, decode always ready.
    do_reset();
    cycle(1'b0, 32'd0, 1'b1, 1'b0, $urandom, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, $urandom, 1'b1);
    chk("stream_credit_stall", {31'd0, bus.imem_req_o}, 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, 1'b1, m_fly.size() != 0, $urandom, 1'b1);
    chk("stream_pc0", acc_pc[0], 32'h0);
    chk("stream_pc1", acc_pc[1], 32'h4);
    chk("stream_pc2", acc_pc[2], 32'h8);

    // Backpressure: decode stalls for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b1, m_fly.size() != 0, $urandom, 1'b0);
    chk("bp_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("bp_valid", {31'd0, bus.instr_valid_o}, 32'd1);
    chk("bp_head_pc", bus.instr_pc_o, 32'h0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("bp_second_pc", bus.instr_pc_o, 32'h4);
    chk("bp_resume_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("bp_resume_addr", bus.imem_addr_o, 32'h8);

    // Grant stall at 0x10, reached by a redirect that withdraws the pending request.
    do_reset();
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'd0, bus.imem_req_o}, 32'd1);
      chk("stall_addr", bus.imem_addr_o, 32'h10);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_advance", bus.imem_addr_o, 32'h14);

    // Redirect with two responses in flight.
    do_reset();
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 32'h103, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("redir_addr", bus.imem_addr_o, 32'h100);
    chk("redir_req0", {31'd0, bus.imem_req_o}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b1);
    chk("redir_req1", {31'd0, bus.imem_req_o}, 32'd0);
    chk("redir_no_stale", {31'd0, bus.instr_valid_o}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_0002, 1'b1);
    chk("redir_req2", {31'd0, bus.imem_req_o}, 32'd1);
    chk("redir_addr2", bus.imem_addr_o, 32'h100);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    chk("redir_first_pc", bus.instr_pc_o, 32'h100);
    chk("redir_first_instr", bus.instr_o, 32'h1234_5678);

    // Redirect, grant and response all in one cycle: one stale response remains.
    do_reset();
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("simul_pre_addr", bus.imem_addr_o, 32'h4);
    cycle(1'b1, 32'h200, 1'b1, 1'b1, 32'hBAD0_0000, 1'b1);
    chk("simul_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("simul_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("simul_addr", bus.imem_addr_o, 32'h200);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'hBAD0_0001, 1'b1);
    chk("simul_restart", {31'd0, bus.imem_req_o}, 32'd1);

    // Async reset in the middle of a flush, then late stale responses.
    do_reset();
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 32'd0, 1'b1);
    do_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD0_0002, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD0_0003, 1'b1);
    chk("late_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("late_addr", bus.imem_addr_o, RPC);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
    chk("late_pc", bus.instr_pc_o, RPC);
    chk("late_instr", bus.instr_o, 32'h5555_AAAA);

    // Randomized traffic, including rare protocol-violating responses and resets.
    for (int i = 0; i < 4000; i++) begin
      if (m_fly.size() != 0) rv = ($urandom_range(99) < 55);
      else rv = ($urandom_range(99) < 3);
      cycle($urandom_range(99) < 5, $urandom, $urandom_range(99) < 65, rv, $urandom,
            $urandom_range(99) < 70);
      if ($urandom_range(999) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
